// File: rtl/inline_axis_comparator.sv
// inline_axis_comparator
//   Passive checker for an AXI-Stream style bus. Every observed handshake
//   (obs_valid & obs_ready) is copied into a small FIFO that never
//   back-pressures the monitored bus. Each buffered sample is compared
//   against the next word of an expected stream (ref_*). The block keeps
//   match/mismatch totals, captures the first mismatch, and reports
//   overflow and stall (watchdog) conditions.
//
// Ports
//   clk, rst (async, active-low), clear (synchronous restart)
//   obs_valid/obs_ready/obs_data/obs_last : monitored bus, input only
//   ref_valid/ref_data/ref_last, ref_ready : expected stream, popped by ref_ready
//   match_count, mismatch_count            : comparison totals (saturating)
//   first_err_index/_seen/_expected/_valid : first-mismatch capture
//   overflow, timeout, halted              : sticky status
module inline_axis_comparator #(
    parameter int DATA_WIDTH     = 10,
    parameter int FIFO_DEPTH     = 16,
    parameter int COUNT_WIDTH    = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int STOP_ON_ERROR  = 0,
    parameter int CHECK_LAST     = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   obs_valid,
    input  logic                   obs_ready,
    input  logic [DATA_WIDTH-1:0]  obs_data,
    input  logic                   obs_last,
    input  logic                   ref_valid,
    input  logic [DATA_WIDTH-1:0]  ref_data,
    input  logic                   ref_last,
    output logic                   ref_ready,
    output logic [COUNT_WIDTH-1:0] match_count,
    output logic [COUNT_WIDTH-1:0] mismatch_count,
    output logic [COUNT_WIDTH-1:0] first_err_index,
    output logic [DATA_WIDTH-1:0]  first_err_seen,
    output logic [DATA_WIDTH-1:0]  first_err_expected,
    output logic                   first_err_valid,
    output logic                   overflow,
    output logic                   timeout,
    output logic                   halted
);

    localparam int          PW        = $clog2(FIFO_DEPTH);
    localparam int          EW        = DATA_WIDTH + 1;
    localparam logic [31:0] TIMEOUT_L = 32'(TIMEOUT_CYCLES);
    localparam logic [PW:0] PTR_ONE   = {{PW{1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    // Saturating increment shared by all counters.
    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (&v) ? v : v + COUNT_WIDTH'(1);
    endfunction

    state_t                 state_q, state_d;
    logic [PW:0]            wr_ptr_q, wr_ptr_d;
    logic [PW:0]            rd_ptr_q, rd_ptr_d;
    logic [EW-1:0]          mem_q [FIFO_DEPTH];
    logic [COUNT_WIDTH-1:0] match_q, match_d;
    logic [COUNT_WIDTH-1:0] mismatch_q, mismatch_d;
    logic [COUNT_WIDTH-1:0] index_q, index_d;
    logic [COUNT_WIDTH-1:0] err_index_q, err_index_d;
    logic [DATA_WIDTH-1:0]  err_seen_q, err_seen_d;
    logic [DATA_WIDTH-1:0]  err_exp_q, err_exp_d;
    logic                   err_valid_q, err_valid_d;
    logic                   overflow_q, overflow_d;
    logic                   timeout_q, timeout_d;
    logic [31:0]            wd_q, wd_d;

    logic                   run_s, empty_s, full_s, obs_txn_s, cmp_s, push_s, match_s;
    logic [EW-1:0]          head_s;

    // FIFO occupancy flags; the extra pointer bit distinguishes full from empty.
    assign empty_s   = (wr_ptr_q == rd_ptr_q);
    assign full_s    = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign head_s    = mem_q[rd_ptr_q[PW-1:0]];
    assign run_s     = (state_q == ST_RUN);
    assign obs_txn_s = obs_valid & obs_ready;

    // clear also gates ref_ready so the reference source never loses a word
    // to a comparison that clear is about to discard.
    assign ref_ready = run_s & ~empty_s & ~clear;
    assign cmp_s     = ref_ready & ref_valid;
    // A full FIFO still takes a write when the same edge frees an entry.
    assign push_s    = obs_txn_s & (~full_s | cmp_s) & ~clear;
    assign match_s   = (head_s[DATA_WIDTH-1:0] == ref_data) &&
                       ((CHECK_LAST == 0) || (head_s[DATA_WIDTH] == ref_last));

    // Next-state logic for the FSM, FIFO pointers, counters, capture and watchdog.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        match_d     = match_q;
        mismatch_d  = mismatch_q;
        index_d     = index_q;
        err_index_d = err_index_q;
        err_seen_d  = err_seen_q;
        err_exp_d   = err_exp_q;
        err_valid_d = err_valid_q;
        overflow_d  = overflow_q;
        timeout_d   = timeout_q;
        wd_d        = wd_q;
        if (clear) begin
            state_d     = ST_RUN;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            match_d     = '0;
            mismatch_d  = '0;
            index_d     = '0;
            err_index_d = '0;
            err_seen_d  = '0;
            err_exp_d   = '0;
            err_valid_d = 1'b0;
            overflow_d  = 1'b0;
            timeout_d   = 1'b0;
            wd_d        = '0;
        end else begin
            if (cmp_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                index_d  = sat_inc(index_q);
                if (match_s) begin
                    match_d = sat_inc(match_q);
                end else begin
                    mismatch_d = sat_inc(mismatch_q);
                    if (!err_valid_q) begin
                        err_valid_d = 1'b1;
                        err_index_d = index_q;
                        err_seen_d  = head_s[DATA_WIDTH-1:0];
                        err_exp_d   = ref_data;
                    end else begin
                        err_valid_d = err_valid_q;
                    end
                    if (STOP_ON_ERROR != 0) begin
                        state_d = ST_HALTED;
                    end else begin
                        state_d = state_q;
                    end
                end
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (obs_txn_s) begin
                if (!full_s || cmp_s) begin
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                end else begin
                    overflow_d = 1'b1;
                end
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            // Watchdog measures how long a buffered sample waits for its reference.
            if (run_s && !empty_s && !cmp_s) begin
                if (wd_q != TIMEOUT_L) begin
                    wd_d = wd_q + 32'd1;
                end else begin
                    wd_d = wd_q;
                end
            end else begin
                wd_d = '0;
            end
            if ((TIMEOUT_CYCLES != 0) && (wd_d == TIMEOUT_L)) begin
                timeout_d = 1'b1;
            end else begin
                timeout_d = timeout_q;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            match_q     <= '0;
            mismatch_q  <= '0;
            index_q     <= '0;
            err_index_q <= '0;
            err_seen_q  <= '0;
            err_exp_q   <= '0;
            err_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            timeout_q   <= 1'b0;
            wd_q        <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            match_q     <= match_d;
            mismatch_q  <= mismatch_d;
            index_q     <= index_d;
            err_index_q <= err_index_d;
            err_seen_q  <= err_seen_d;
            err_exp_q   <= err_exp_d;
            err_valid_q <= err_valid_d;
            overflow_q  <= overflow_d;
            timeout_q   <= timeout_d;
            wd_q        <= wd_d;
        end
    end

    // Sample storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q[PW-1:0]] <= {obs_last, obs_data};
        end
    end

    assign match_count        = match_q;
    assign mismatch_count     = mismatch_q;
    assign first_err_index    = err_index_q;
    assign first_err_seen     = err_seen_q;
    assign first_err_expected = err_exp_q;
    assign first_err_valid    = err_valid_q;
    assign overflow           = overflow_q;
    assign timeout            = timeout_q;
    assign halted             = (state_q == ST_HALTED);

endmodule

// File: doc/inline_axis_comparator.md
INLINE_AXIS_COMPARATOR -- requirements
Module: inline_axis_comparator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 10: width of observed and reference data.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16: observed-sample buffer entries; power of two, minimum 2.
REQ-003 SHALL have parameter COUNT_WIDTH, default 32: width of every counter and index output.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024: stall limit; 0 disables the watchdog.
REQ-005 SHALL have parameter STOP_ON_ERROR, default 0: 1 halts comparison on first mismatch.
REQ-006 SHALL have parameter CHECK_LAST, default 1: 1 includes TLAST in the comparison.
REQ-007 clk  in  1  sole clock, all state on rising edge.
REQ-008 rst  in  1  reset, asynchronous, active-low.
REQ-009 clear  in  1  synchronous restart of all state except FIFO_DEPTH-independent parameters.
REQ-010 obs_valid, obs_ready  in  1 each  monitored bus handshake, never driven.
REQ-011 obs_data  in  DATA_WIDTH; obs_last  in  1  monitored payload.
REQ-012 ref_valid  in  1; ref_data  in  DATA_WIDTH; ref_last  in  1  expected stream.
REQ-013 ref_ready  out  1  pop of expected stream.
REQ-014 match_count, mismatch_count  out  COUNT_WIDTH  comparison totals.
REQ-015 first_err_index  out  COUNT_WIDTH; first_err_seen, first_err_expected  out  DATA_WIDTH  first-mismatch capture.
REQ-016 first_err_valid, overflow, timeout, halted  out  1 each  sticky status.

Function
REQ-017 An observed transaction SHALL be obs_valid&obs_ready at a rising edge; {obs_last, obs_data} is written to the FIFO that edge, readable the next cycle.
REQ-018 The FIFO SHALL be never back-pressured; a transaction when full and no same-cycle pop SHALL be dropped and set overflow.
REQ-019 Full with simultaneous pop SHALL accept the write, no overflow.
REQ-020 State machine SHALL have states RUN and HALTED; reset and clear enter RUN.
REQ-021 In RUN, ref_ready SHALL be combinationally 1 iff FIFO non-empty; a comparison occurs when ref_valid&ref_ready, popping one FIFO entry.
REQ-022 Comparison SHALL match iff data equal and, when CHECK_LAST=1, last equal; CHECK_LAST=0 ignores last.
REQ-023 Counters and status SHALL update at the edge ending the comparison cycle (1-cycle latency); counters saturate at all-ones.
REQ-024 Sample index SHALL start at 0 and increment per comparison (saturating); on first mismatch capture index, observed data, expected data, and set first_err_valid; later mismatches leave capture unchanged.
REQ-025 STOP_ON_ERROR=1: first mismatch SHALL move to HALTED; in HALTED ref_ready=0, FIFO still accepts writes, halted=1.
REQ-026 Watchdog: counter SHALL increment each RUN cycle with FIFO non-empty and no comparison, reset to 0 on comparison or empty FIFO; reaching TIMEOUT_CYCLES sets timeout (sticky), comparison continues.
REQ-027 clear SHALL flush FIFO, zero counters, index, capture, flags, watchdog; a concurrent observed transaction is discarded; clear overrides all other events.

Reset
REQ-028 rst low SHALL asynchronously force all outputs 0, FIFO empty, state RUN; operation resumes the first edge after release.
REQ-029 Reset mid-stream SHALL discard buffered samples without flagging overflow or mismatch.

Verification
REQ-030 Observe 0x001..0x008 with matching reference, ref_valid always 1 -> match_count=8, mismatch_count=0, ref_ready pulses 8 times.
REQ-031 Reference 0x010,0x011,0x012; observed 0x010,0x0FF,0x012 -> mismatch_count=1, first_err_index=1, seen=0x0FF, expected=0x011, match_count=2.
REQ-032 FIFO_DEPTH=4, ref_valid=0, observe 6 samples -> overflow=1 after 5th; then ref_valid=1 -> exactly 4 comparisons.
REQ-033 TIMEOUT_CYCLES=10, one observed sample, ref_valid=0 -> timeout=1 exactly 10 cycles after sample readable; no counter changes.
REQ-034 STOP_ON_ERROR=1, mismatch at index 2 of 5 -> halted=1, ref_ready=0 thereafter, match_count=2; clear -> all outputs 0, RUN.
REQ-035 CHECK_LAST=1, equal data, obs_last=1 vs ref_last=0 -> mismatch_count=1; same with CHECK_LAST=0 -> match.
